// File: rtl/ir_pkg.sv
// ir_pkg: shared state/colour types and per-car burst lengths for the IR transmitter
package ir_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_GAP_S, S_CAR, S_GAP_C, S_BIT, S_GAP_B} state_t;
  typedef enum logic [1:0] {CAR_BLUE, CAR_YELLOW, CAR_GREEN, CAR_RED} car_t;
  typedef struct packed {
    logic [7:0] start_len;
    logic [7:0] car_len;
    logic [7:0] gap_len;
    logic [7:0] assert_len;
    logic [7:0] deassert_len;
  } burst_cfg_t;
  localparam burst_cfg_t BURST_TABLE [4] = '{
    '{8'd191, 8'd47, 8'd25, 8'd47, 8'd22},
    '{8'd88,  8'd22, 8'd40, 8'd44, 8'd22},
    '{8'd88,  8'd44, 8'd40, 8'd44, 8'd22},
    '{8'd192, 8'd24, 8'd24, 8'd48, 8'd24}
  };
endpackage

// File: rtl/ir_packet_fsm.sv
// ir_packet_fsm: sequences one packet's bursts and gaps, advancing only on carrier ticks
module ir_packet_fsm
  import ir_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       carrier,
  input  logic       start,
  input  logic [3:0] cmd,
  input  burst_cfg_t cfg,
  output logic       ir_led,
  output logic       busy,
  output logic       packet_done
);
  state_t     state_q, state_d;
  logic [7:0] dur_q, dur_d, len_cur, len_nxt;
  logic [1:0] idx_q, idx_d, nidx;
  logic [3:0] cmd_q, cmd_d;
  burst_cfg_t cfg_q, cfg_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       unused_start;
  assign unused_start = ^cfg_q.start_len;
  // next state and duration reload; IDLE snapshots the request so later writes only affect the next packet
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    nidx    = idx_q + 2'd1;
    len_cur = cmd_q[idx_q] ? cfg_q.assert_len : cfg_q.deassert_len;
    len_nxt = cmd_q[nidx] ? cfg_q.assert_len : cfg_q.deassert_len;
    if (tick && state_q == S_IDLE && start) begin
      state_d = S_START;
      dur_d   = cfg.start_len - 8'd1;
      idx_d   = 2'd0;
      cmd_d   = cmd;
      cfg_d   = cfg;
    end else if (tick && state_q != S_IDLE && dur_q != 8'd0) begin
      dur_d = dur_q - 8'd1;
    end else if (tick) begin
      case (state_q)
        S_START: begin state_d = S_GAP_S; dur_d = cfg_q.gap_len - 8'd1; end
        S_GAP_S: begin state_d = S_CAR;   dur_d = cfg_q.car_len - 8'd1; end
        S_CAR:   begin state_d = S_GAP_C; dur_d = cfg_q.gap_len - 8'd1; end
        S_GAP_C: begin state_d = S_BIT;   dur_d = len_cur - 8'd1; end
        S_BIT:   begin state_d = S_GAP_B; dur_d = cfg_q.gap_len - 8'd1; end
        S_GAP_B: begin
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_BIT;
            idx_d   = nidx;
            dur_d   = len_nxt - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = state_d != S_IDLE;
  end
  // packet registers; reset aborts any packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dur_q   <= '0;
      idx_q   <= '0;
      cmd_q   <= '0;
      cfg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      cfg_q   <= cfg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign ir_led      = carrier && (state_q inside {S_START, S_CAR, S_BIT});
  assign busy        = busy_q;
  assign packet_done = done_q;
endmodule

// File: rtl/ir_transmitter_multi.sv
// ir_transmitter_multi: bus-programmable IR car-control transmitter in a single clock domain
module ir_transmitter_multi
  import ir_pkg::*;
#(
  parameter logic [7:0] IO_ADDRESS    = 8'h90,
  parameter int         CARRIER_DIV   = 2500,
  parameter int         PACKET_PERIOD = 4000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BUS_WE,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA,
  output logic       IR_LED,
  output logic       BUSY,
  output logic       PACKET_DONE
);
  localparam int             CW     = $clog2(CARRIER_DIV);
  localparam int             TW     = $clog2(PACKET_PERIOD);
  localparam logic [CW-1:0]  C_LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0]  C_HALF = CW'(CARRIER_DIV / 2);
  localparam logic [TW-1:0]  T_LAST = TW'(PACKET_PERIOD - 1);
  localparam logic [7:0]     A_CMD  = IO_ADDRESS;
  localparam logic [7:0]     A_SEL  = IO_ADDRESS + 8'd1;
  localparam logic [7:0]     A_CTL  = IO_ADDRESS + 8'd2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cmd_q, cmd_d;
  car_t          sel_q, sel_d;
  logic          per_en_q, per_en_d, pending_q, pending_d;
  logic          wr_cmd, wr_sel, wr_ctl, send_now, tick, carrier, wrap, req, accept;
  logic          unused_data;
  assign unused_data = ^BUS_DATA[7:4];
  assign wr_cmd   = BUS_WE && BUS_ADDR == A_CMD;
  assign wr_sel   = BUS_WE && BUS_ADDR == A_SEL;
  assign wr_ctl   = BUS_WE && BUS_ADDR == A_CTL;
  assign send_now = wr_ctl && BUS_DATA[1];
  assign tick     = cnt_q == C_LAST;
  assign carrier  = cnt_q < C_HALF;
  assign wrap     = per_en_q && tick && timer_q == T_LAST;
  // a timer expiry is seen on its own tick so the first periodic packet starts PACKET_PERIOD ticks after reset
  assign req      = pending_q || wrap;
  assign accept   = tick && req && !BUSY;
  // register writes, carrier divider, packet timer and the single merged request flag
  always_comb begin
    cmd_d     = wr_cmd ? BUS_DATA[3:0] : cmd_q;
    sel_d     = wr_sel ? car_t'(BUS_DATA[1:0]) : sel_q;
    per_en_d  = wr_ctl ? BUS_DATA[0] : per_en_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    timer_d   = !per_en_q ? '0 : !tick ? timer_q : (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
    pending_d = accept ? 1'b0 : (pending_q || wrap || send_now);
  end
  // peripheral state registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q     <= '0;
      timer_q   <= '0;
      cmd_q     <= '0;
      sel_q     <= CAR_YELLOW;
      per_en_q  <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      cmd_q     <= cmd_d;
      sel_q     <= sel_d;
      per_en_q  <= per_en_d;
      pending_q <= pending_d;
    end
  end
  ir_packet_fsm u_fsm (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .tick        (tick),
    .carrier     (carrier),
    .start       (req),
    .cmd         (cmd_q),
    .cfg         (BURST_TABLE[sel_q]),
    .ir_led      (IR_LED),
    .busy        (BUSY),
    .packet_done (PACKET_DONE)
  );
endmodule

// File: tb/tb_ir_transmitter_multi.sv
// tb_ir_transmitter_multi: scoreboard bench measuring whole packets against expected burst sequences
module tb_ir_transmitter_multi;
  localparam logic [7:0] BASE = 8'h90;
  typedef struct packed {
    logic [31:0] start;
    logic [95:0] segs;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0;
  logic [7:0]  addr = '0, data = '0;
  logic        led, busy, done;
  int          cyc, checks, errors, npkt;
  exp_t        expq[$];
  exp_t        e;
  int          tbl [4][5] = '{'{191, 47, 25, 47, 22}, '{88, 22, 40, 44, 22},
                              '{88, 44, 40, 44, 22}, '{192, 24, 24, 48, 24}};
  logic        in_pkt, cur;
  logic [3:0]  pat;
  logic [95:0] mseg;
  int          st, nseg, run, ph, badp;

  ir_transmitter_multi #(.IO_ADDRESS(BASE), .CARRIER_DIV(4), .PACKET_PERIOD(1000)) dut (
    .CLK(clk), .RESET_N(rst_n), .BUS_WE(we), .BUS_ADDR(addr), .BUS_DATA(data),
    .IR_LED(led), .BUSY(busy), .PACKET_DONE(done));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int car, input logic [3:0] cmd);
    exp_t r;
    int v [12];
    v[0] = tbl[car][0];
    v[1] = tbl[car][2];
    v[2] = tbl[car][1];
    v[3] = tbl[car][2];
    for (int i = 0; i < 4; i++) begin
      v[4+2*i] = cmd[i] ? tbl[car][3] : tbl[car][4];
      v[5+2*i] = tbl[car][2];
    end
    r.start = 32'(s);
    r.segs  = '0;
    for (int i = 0; i < 12; i++) r.segs[8*i +: 8] = 8'(v[i]);
    return r;
  endfunction

  function automatic int total(input logic [95:0] s);
    int t = 0;
    for (int i = 0; i < 12; i++) t += int'(s[8*i +: 8]);
    return t;
  endfunction

  task automatic seg_push();
    if (nseg < 12) mseg[8*nseg +: 8] = 8'(run);
    nseg++;
  endtask

  // monitor: slices each packet into carrier periods, run-length encodes bursts/gaps, checks at PACKET_DONE
  always @(negedge clk) begin
    if (!rst_n) in_pkt = 1'b0;
    else begin
      if (busy && !in_pkt) begin
        in_pkt = 1'b1; st = cyc; nseg = 0; run = 0; cur = 1'b1; badp = 0; mseg = '0;
      end
      if (busy && in_pkt) begin
        ph = (cyc - st) % 4;
        pat[3-ph] = led;
        if (ph == 3) begin
          if (pat != 4'b1100 && pat != 4'b0000) badp++;
          if ((pat == 4'b1100) == cur) run++;
          else begin
            seg_push();
            cur = pat == 4'b1100;
            run = 1;
          end
        end
      end
      if (done) begin
        npkt++;
        if (!in_pkt) begin
          checks++; errors++;
          $display("FAIL stray_done at cycle %0d got pulse exp none", cyc);
        end else if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_packet started %0d got packet exp none", st);
          in_pkt = 1'b0;
        end else begin
          seg_push();
          e = expq.pop_front();
          chk("pkt_start", 96'(st), 96'(e.start));
          chk("pkt_nseg", 96'(nseg), 96'(12));
          chk("pkt_segs", mseg, e.segs);
          chk("pkt_len", 96'(cyc - st), 96'(4 * total(e.segs)));
          chk("pkt_pattern", 96'(badp), 96'(0));
          in_pkt = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d, output int c);
    @(negedge clk);
    we = 1'b1; addr = a; data = d; c = cyc;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin @(negedge clk); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout got no pulse in %0d cycles exp pulse", n);
    end
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < t + 10) begin @(negedge clk); n++; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    int c, red_start, gs;
    repeat (3) @(negedge clk);
    chk("rst_led", 96'(led), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    expq.push_back(mk(4000, 1, 4'h0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 96'(busy), 96'(0));
    wait_done(6000);
    wr(BASE + 8'd2, 8'h00, c);
    wr(BASE + 8'd1, 8'h03, c);
    wr(BASE + 8'd0, 8'h0A, c);
    wr(BASE + 8'd2, 8'h02, c);
    red_start = ((c + 5) / 4) * 4;
    expq.push_back(mk(red_start, 3, 4'b1010));
    wait_cyc(red_start + 200);
    chk("mid_busy", 96'(busy), 96'(1));
    wr(BASE + 8'd2, 8'h02, c);
    expq.push_back(mk(red_start + 2020, 2, 4'b0101));
    wr(BASE + 8'd0, 8'h05, c);
    wr(BASE + 8'd1, 8'h02, c);
    wr(BASE + 8'd2, 8'h02, c);
    wait_done(3000);
    wait_done(3000);
    wr(BASE + 8'd2, 8'h02, c);
    gs = ((c + 5) / 4) * 4;
    wait_cyc(gs + 552);
    chk("car_led_high", 96'(led), 96'(1));
    chk("car_busy", 96'(busy), 96'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_led_now", 96'(led), 96'(0));
    chk("rst_busy_now", 96'(busy), 96'(0));
    chk("rst_done_now", 96'(done), 96'(0));
    repeat (2) @(negedge clk);
    expq.push_back(mk(4000, 1, 4'h0));
    rst_n = 1'b1;
    wait_cyc(3998);
    wr(BASE + 8'd2, 8'h03, c);
    wait_done(2500);
    wait_cyc(7000);
    chk("busy_quiet", 96'(busy), 96'(0));
    chk("queue_empty", 96'(expq.size()), 96'(0));
    chk("packet_count", 96'(npkt), 96'(4));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
